multiexp_feeder: RTL and testbench

- Source side of the multiexp point/scalar stream.
- Buffers NUM_IN (point, scalar) pairs loaded once from the host/DMA stream.
- Replays the full set NUM_PASSES times as one continuous stream, NUM_IN*NUM_PASSES beats, in the order the multiexp top consumes it.
- Sits between the loader and the multiexp top. Frees the host from re-sending the data set for every key bit.

---
 rtl/multiexp_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_multiexp_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_feeder.sv
// -----------------------------------------------------------------------------
// multiexp_feeder
//   Source side of the multiexp point/scalar stream. A set of NUM_IN
//   {point, scalar} pairs is loaded once from the host/DMA stream into a local
//   RAM. On i_start the set is replayed NUM_PASSES times as one continuous
//   stream of NUM_IN*NUM_PASSES beats, so the host does not re-send the data
//   for every key bit.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load_val/eop/dat  load stream in, dat = {point, scalar}
//   o_load_rdy          load stream ready (high while not replaying)
//   i_start             one-cycle pulse, starts replay when a set is held
//   o_pnt_scl_*         replay stream out (val/sop/eop/dat/ctl/mod/err, rdy in)
//                       sop on idx 0, eop on idx NUM_IN-1, ctl = pass index
//   o_busy              start accepted until the last beat is transferred
//   o_loaded            a complete set is held
//   o_err               sticky load-framing error, cleared only by i_rst
//
// Optional feature (macro MULTIEXP_FEEDER_STALL_CNT_EN)
//   o_stall_cnt [31:0]  replay cycles with val=1 && rdy=0; cleared on each
//                       accepted start, saturating.
// -----------------------------------------------------------------------------
module multiexp_feeder #(
  parameter int PNT_BITS   = 762,
  parameter int SCL_BITS   = 381,
  parameter int NUM_IN     = 16,
  parameter int NUM_PASSES = SCL_BITS,
  parameter int MOD_BITS   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load_val,
  input  logic                         i_load_eop,
  input  logic [PNT_BITS+SCL_BITS-1:0] i_load_dat,
  output logic                         o_load_rdy,
  input  logic                         i_start,
  output logic                         o_pnt_scl_val,
  output logic                         o_pnt_scl_sop,
  output logic                         o_pnt_scl_eop,
  output logic [PNT_BITS+SCL_BITS-1:0] o_pnt_scl_dat,
  output logic [7:0]                   o_pnt_scl_ctl,
  output logic [MOD_BITS-1:0]          o_pnt_scl_mod,
  output logic                         o_pnt_scl_err,
  input  logic                         i_pnt_scl_rdy,
  output logic                         o_busy,
  output logic                         o_loaded,
  output logic                         o_err
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]                  o_stall_cnt
`endif
);

  localparam int DAT_W  = PNT_BITS + SCL_BITS;
  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int PASS_W = ($clog2(NUM_PASSES) > 8) ? $clog2(NUM_PASSES) : 8;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, STREAM} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                loaded_q, loaded_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                load_rdy_q, load_rdy_d;

  // read issue side
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic                issue_done_q, issue_done_d;

  // beat in flight through the RAM read register
  logic                rv_vld_q, rv_vld_d;
  logic                rv_sop_q, rv_sop_d;
  logic                rv_eop_q, rv_eop_d;
  logic [7:0]          rv_ctl_q, rv_ctl_d;
  logic                rv_last_q, rv_last_d;

  // output register
  logic                out_vld_q, out_vld_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [7:0]          out_ctl_q, out_ctl_d;
  logic                out_last_q, out_last_d;
  logic [DAT_W-1:0]    out_dat_q, out_dat_d;

  // skid entry, catches the in-flight read when the output is stalled
  logic                skid_vld_q, skid_vld_d;
  logic                skid_sop_q, skid_sop_d;
  logic                skid_eop_q, skid_eop_d;
  logic [7:0]          skid_ctl_q, skid_ctl_d;
  logic                skid_last_q, skid_last_d;
  logic [DAT_W-1:0]    skid_dat_q, skid_dat_d;

`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
  logic [31:0]         stall_cnt_q, stall_cnt_d;
`endif

  // RAM
  logic [DAT_W-1:0]    ram_q [NUM_IN];
  logic [DAT_W-1:0]    ram_rd_q;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic                rd_en;

  logic                load_acc, start_acc, xfer;
  logic [1:0]          occ;

  always_comb begin
    load_acc  = i_load_val && load_rdy_q;
    // a load beat in the same cycle wins over start: the held set is being replaced
    start_acc = (state_q == IDLE) && i_start && loaded_q && !load_acc;
    xfer      = out_vld_q && i_pnt_scl_rdy;
    // out + skid hold two beats; a read is only issued if it will have a slot
    // when it lands, counting whatever leaves the output this cycle
    occ       = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rv_vld_q};
    rd_en     = (state_q == STREAM) && !issue_done_q && ((occ - {1'b0, xfer}) < 2'd2);

    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    loaded_d     = loaded_q;
    err_d        = err_q;
    busy_d       = busy_q;
    rd_idx_d     = rd_idx_q;
    pass_cnt_d   = pass_cnt_q;
    issue_done_d = issue_done_q;
    wr_en        = 1'b0;
    wr_addr      = wr_cnt_q;

    case (state_q)
      IDLE: begin
        if (load_acc) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          loaded_d = 1'b0;
          if (i_load_eop) begin
            err_d = 1'b1;                  // single-beat set is always short
          end else begin
            wr_cnt_d = IDX_W'(1);
            state_d  = LOAD;
          end
        end else if (start_acc) begin
          state_d      = STREAM;
          busy_d       = 1'b1;
          rd_idx_d     = '0;
          pass_cnt_d   = '0;
          issue_done_d = 1'b0;
        end
      end
      LOAD: begin
        if (load_acc) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            if (i_load_eop) begin
              loaded_d = 1'b1;
              state_d  = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else begin
            wr_cnt_d = wr_cnt_q + IDX_W'(1);
            if (i_load_eop) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        if (load_acc && i_load_eop) state_d = IDLE;
      end
      STREAM: begin
        if (xfer && out_last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    load_rdy_d = (state_d != STREAM);

    // read issue: walk idx, bump pass on wrap, stop after the final beat
    if (rd_en) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d = '0;
        if (pass_cnt_q == LAST_PASS) issue_done_d = 1'b1;
        else                         pass_cnt_d   = pass_cnt_q + PASS_W'(1);
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end

    rv_vld_d  = rd_en;
    rv_sop_d  = (rd_idx_q == '0);
    rv_eop_d  = (rd_idx_q == LAST_IDX);
    rv_ctl_d  = pass_cnt_q[7:0];
    rv_last_d = (rd_idx_q == LAST_IDX) && (pass_cnt_q == LAST_PASS);

    out_vld_d   = out_vld_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_ctl_d   = out_ctl_q;
    out_last_d  = out_last_q;
    out_dat_d   = out_dat_q;
    skid_vld_d  = skid_vld_q;
    skid_sop_d  = skid_sop_q;
    skid_eop_d  = skid_eop_q;
    skid_ctl_d  = skid_ctl_q;
    skid_last_d = skid_last_q;
    skid_dat_d  = skid_dat_q;

    if (!out_vld_q || xfer) begin
      // output is free: skid drains first to keep order, read data backfills
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_sop_d   = skid_sop_q;
        out_eop_d   = skid_eop_q;
        out_ctl_d   = skid_ctl_q;
        out_last_d  = skid_last_q;
        out_dat_d   = skid_dat_q;
        skid_vld_d  = rv_vld_q;
        skid_sop_d  = rv_sop_q;
        skid_eop_d  = rv_eop_q;
        skid_ctl_d  = rv_ctl_q;
        skid_last_d = rv_last_q;
        skid_dat_d  = ram_rd_q;
      end else if (rv_vld_q) begin
        out_vld_d  = 1'b1;
        out_sop_d  = rv_sop_q;
        out_eop_d  = rv_eop_q;
        out_ctl_d  = rv_ctl_q;
        out_last_d = rv_last_q;
        out_dat_d  = ram_rd_q;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (rv_vld_q) begin
      // output held by backpressure: park the landing read
      skid_vld_d  = 1'b1;
      skid_sop_d  = rv_sop_q;
      skid_eop_d  = rv_eop_q;
      skid_ctl_d  = rv_ctl_q;
      skid_last_d = rv_last_q;
      skid_dat_d  = ram_rd_q;
    end

`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    stall_cnt_d = stall_cnt_q;
    if (start_acc)
      stall_cnt_d = '0;
    else if ((state_q == STREAM) && out_vld_q && !i_pnt_scl_rdy && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      load_rdy_q   <= 1'b0;
      rd_idx_q     <= '0;
      pass_cnt_q   <= '0;
      issue_done_q <= 1'b0;
      rv_vld_q     <= 1'b0;
      rv_sop_q     <= 1'b0;
      rv_eop_q     <= 1'b0;
      rv_ctl_q     <= '0;
      rv_last_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_ctl_q    <= '0;
      out_last_q   <= 1'b0;
      out_dat_q    <= '0;
      skid_vld_q   <= 1'b0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      skid_ctl_q   <= '0;
      skid_last_q  <= 1'b0;
      skid_dat_q   <= '0;
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      load_rdy_q   <= load_rdy_d;
      rd_idx_q     <= rd_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      issue_done_q <= issue_done_d;
      rv_vld_q     <= rv_vld_d;
      rv_sop_q     <= rv_sop_d;
      rv_eop_q     <= rv_eop_d;
      rv_ctl_q     <= rv_ctl_d;
      rv_last_q    <= rv_last_d;
      out_vld_q    <= out_vld_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_ctl_q    <= out_ctl_d;
      out_last_q   <= out_last_d;
      out_dat_q    <= out_dat_d;
      skid_vld_q   <= skid_vld_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
      skid_ctl_q   <= skid_ctl_d;
      skid_last_q  <= skid_last_d;
      skid_dat_q   <= skid_dat_d;
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  // set storage with registered read; contents need no reset, validity is loaded_q
  always_ff @(posedge i_clk) begin
    if (wr_en) ram_q[wr_addr] <= i_load_dat;
    if (rd_en) ram_rd_q <= ram_q[rd_idx_q];
  end

  assign o_load_rdy    = load_rdy_q;
  assign o_pnt_scl_val = out_vld_q;
  assign o_pnt_scl_sop = out_sop_q;
  assign o_pnt_scl_eop = out_eop_q;
  assign o_pnt_scl_dat = out_dat_q;
  assign o_pnt_scl_ctl = out_ctl_q;
  assign o_pnt_scl_mod = '0;
  assign o_pnt_scl_err = 1'b0;
  assign o_busy        = busy_q;
  assign o_loaded      = loaded_q;
  assign o_err         = err_q;
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
  assign o_stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multiexp_feeder.sv
module tb_multiexp_feeder;
  localparam int PB = 16, SB = 8, DW = PB + SB, NI = 4, NP = 8, NB = NI * NP;
  localparam int NO_CYC = 100000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_val = 1'b0, ld_eop = 1'b0, ld_rdy;
  logic [DW-1:0] ld_dat = '0;
  logic          start = 1'b0;
  logic          val, sop, eop, perr;
  logic [DW-1:0] dat;
  logic [7:0]    ctl, mod;
  logic          rdy = 1'b1;
  logic          busy, loaded, err;
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  multiexp_feeder #(.PNT_BITS(PB), .SCL_BITS(SB), .NUM_IN(NI), .NUM_PASSES(NP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_load_val(ld_val), .i_load_eop(ld_eop), .i_load_dat(ld_dat), .o_load_rdy(ld_rdy),
    .i_start(start),
    .o_pnt_scl_val(val), .o_pnt_scl_sop(sop), .o_pnt_scl_eop(eop), .o_pnt_scl_dat(dat),
    .o_pnt_scl_ctl(ctl), .o_pnt_scl_mod(mod), .o_pnt_scl_err(perr), .i_pnt_scl_rdy(rdy),
    .o_busy(busy), .o_loaded(loaded), .o_err(err)
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic [7:0]    ctl;
  } beat_t;

  beat_t sb[$];
  int checks = 0, errors = 0, tb_stall = 0, beats_seen = 0;
  logic          prev_hold = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  function automatic logic [DW-1:0] mk_dat(input logic [7:0] base, input int idx);
    logic [7:0] i8;
    i8 = 8'(idx);
    return {base, i8, base ^ i8 ^ 8'hA5};
  endfunction

  // scoreboard monitor: pops one expected beat per transfer, checks AXI hold
  always @(negedge clk) begin
    if (prev_hold && !rst) begin
      checks++;
      if (!val || dat !== prev_dat || sop !== prev_sop || eop !== prev_eop) begin
        errors++;
        $display("FAIL hold: val=%0b dat=%h sop=%0b eop=%0b required val=1 dat=%h sop=%0b eop=%0b",
                 val, dat, sop, eop, prev_dat, prev_sop, prev_eop);
      end
    end
    prev_hold = val && !rdy;
    prev_dat  = dat;
    prev_sop  = sop;
    prev_eop  = eop;
    if (val && !rdy) tb_stall++;
    if (val && rdy) begin
      beat_t got, exp_b;
      got = {dat, sop, eop, ctl};
      beats_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: dat=%h sop=%0b eop=%0b ctl=%0d with none pending", dat, sop, eop, ctl);
      end else begin
        exp_b = sb.pop_front();
        if (got !== exp_b) begin
          errors++;
          $display("FAIL beat: got dat=%h sop=%0b eop=%0b ctl=%0d required dat=%h sop=%0b eop=%0b ctl=%0d",
                   dat, sop, eop, ctl, exp_b.dat, exp_b.sop, exp_b.eop, exp_b.ctl);
        end
      end
    end
  end

  task automatic load_set(input logic [7:0] base, input int n, input int eop_at);
    for (int i = 0; i < n; i++) begin
      int t;
      ld_val = 1'b1;
      ld_dat = mk_dat(base, i);
      ld_eop = (i == eop_at);
      t = 0;
      @(negedge clk);
      while (!ld_rdy && t < 50) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 50) begin
        errors++;
        $display("FAIL load_handshake: beat %0d rdy=%0b required 1 within 50 cycles", i, ld_rdy);
      end
      @(posedge clk); #1;
    end
    ld_val = 1'b0;
    ld_eop = 1'b0;
  endtask

  task automatic push_run(input logic [7:0] base);
    for (int k = 0; k < NB; k++) begin
      beat_t b;
      b.dat = mk_dat(base, k % NI);
      b.sop = (k % NI == 0);
      b.eop = (k % NI == NI - 1);
      b.ctl = 8'(k / NI);
      sb.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    tb_stall = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // drives rdy (pct % high, optional 25-cycle low window) until all expected beats are out
  task automatic run_until_empty(input int pct, input int lo_at, input int mid_start_at);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 2000) begin
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      if (cyc >= lo_at && cyc < lo_at + 25) rdy = 1'b0;
      start = (cyc == mid_start_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    rdy   = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL run_timeout: %0d beats still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({val, sop, eop, dat, ctl, mod, perr} !== '0) begin
      errors++;
      $display("FAIL reset_out: val=%0b sop=%0b eop=%0b dat=%h ctl=%h mod=%h err=%0b required all 0",
               val, sop, eop, dat, ctl, mod, perr);
    end
    checks++;
    if ({ld_rdy, busy, loaded, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_status: rdy/busy/loaded/err=%b required 0000", {ld_rdy, busy, loaded, err});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ld_rdy !== 1'b1) begin
      errors++;
      $display("FAIL idle_rdy: load rdy=%0b required 1", ld_rdy);
    end
  endtask

  task automatic test_stream();
    int lat;
    load_set(8'h10, NI, NI - 1);
    checks++;
    if (loaded !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL load_ok: loaded=%0b err=%0b required 1 0", loaded, err);
    end
    push_run(8'h10);
    beats_seen = 0;
    rdy = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || ld_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stream_enter: busy=%0b load_rdy=%0b required 1 0", busy, ld_rdy);
    end
    lat = 0;
    while (!val && lat < 2) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (val !== 1'b1) begin
      errors++;
      $display("FAIL first_val: val=%0b after %0d cycles required 1 within 2", val, lat);
    end
    checks++;
    if ({mod, perr} !== '0) begin
      errors++;
      $display("FAIL mod_err: mod=%h err=%0b required 0", mod, perr);
    end
    run_until_empty(100, NO_CYC, NO_CYC);
    checks++;
    if (busy !== 1'b0 || val !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL stream_end: busy=%0b val=%0b loaded=%0b required 0 0 1", busy, val, loaded);
    end
    checks++;
    if (beats_seen != NB) begin
      errors++;
      $display("FAIL beat_count: %0d required %0d", beats_seen, NB);
    end
  endtask

  task automatic test_backpressure();
    load_set(8'h20, NI, NI - 1);
    push_run(8'h20);
    pulse_start();
    run_until_empty(70, 12, NO_CYC);
    checks++;
    if (busy !== 1'b0 || val !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: busy=%0b val=%0b required 0 0", busy, val);
    end
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'(tb_stall)) begin
      errors++;
      $display("FAIL stall_cnt: %0d required %0d", stall_cnt, tb_stall);
    end
`endif
  endtask

  task automatic test_short_load();
    logic saw;
    load_set(8'h30, 3, 2);
    checks++;
    if (err !== 1'b1 || loaded !== 1'b0 || ld_rdy !== 1'b1) begin
      errors++;
      $display("FAIL short_load: err=%0b loaded=%0b rdy=%0b required 1 0 1", err, loaded, ld_rdy);
    end
    pulse_start();
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (val || busy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL start_unloaded: activity=%0b required 0", saw);
    end
  endtask

  task automatic test_long_load();
    load_set(8'h40, 6, 5);
    checks++;
    if (err !== 1'b1 || loaded !== 1'b0 || ld_rdy !== 1'b1) begin
      errors++;
      $display("FAIL long_load: err=%0b loaded=%0b rdy=%0b required 1 0 1", err, loaded, ld_rdy);
    end
    load_set(8'h41, NI, NI - 1);
    checks++;
    if (loaded !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: loaded=%0b err=%0b required 1 1", loaded, err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%0b loaded=%0b required 0 0", err, loaded);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_set(8'h50, NI, NI - 1);
    push_run(8'h50);
    rdy = 1'b1;
    pulse_start();
    cyc = 0;
    while (sb.size() > NB - 10 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (val !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: val=%0b busy=%0b loaded=%0b required 0 0 0", val, busy, loaded);
    end
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    load_set(8'h51, NI, NI - 1);
    push_run(8'h51);
    pulse_start();
    run_until_empty(100, NO_CYC, NO_CYC);
    checks++;
    if (busy !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL rerun_end: busy=%0b loaded=%0b required 0 1", busy, loaded);
    end
  endtask

  task automatic test_back_to_back();
    logic saw;
    load_set(8'h60, NI, NI - 1);
    push_run(8'h60);
    pulse_start();
    run_until_empty(100, NO_CYC, 6);
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (val || busy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: activity after run=%0b required 0", saw);
    end
    push_run(8'h60);
    pulse_start();
    run_until_empty(100, NO_CYC, NO_CYC);
    checks++;
    if (busy !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL second_run: busy=%0b loaded=%0b required 0 1", busy, loaded);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_short_load();
    test_long_load();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
